// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// control state encoding and the sizing rule for the iteration counter.
package mult_pkg;

  // Control FSM states; encoding fixed at 2 bits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Iteration counter width for an N-bit operand: clog2(N), never below 1.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  // Default operand width and the matching counter width.
  localparam int DEF_N     = 8;
  localparam int DEF_CNT_W = cnt_width(DEF_N);

endpackage

// File: rtl/mult_ctrl.sv
// Control sequencer for the shift-and-add multiplier.
// IDLE waits for a start request, RUN lasts exactly N edges regardless of
// operand values, DONE is a single-cycle result strobe. Busy/Done come from
// flops so downstream enables never see a combinational path from inputs.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(N);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            busy_q;
  logic            busy_d;
  logic            done_q;
  logic            done_d;

  // Next-state, counter and datapath enable decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        shift = 1'b1;
        cnt_d = cnt_q + CW'(1);
        // The N-th RUN edge is the one that sees count = N-1.
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Status flags follow the state the FSM is entering, so after the
    // register they line up exactly with the state they describe.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, counter and status registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: 2N-bit product of two N-bit
// operands in N RUN cycles, followed by a one-cycle Done strobe. The product
// output is the accumulator register itself and stays stable after DONE
// until the next accepted Start clears it.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             Start,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             Busy,
  output logic             Done,
  output logic [2*N-1:0]   P
);

  logic               load_s;
  logic               shift_s;
  logic [2*N-1:0]     acc_q;
  logic [2*N-1:0]     acc_d;
  logic [2*N-1:0]     mcand_q;
  logic [2*N-1:0]     mcand_d;
  logic [N-1:0]       mplr_q;
  logic [N-1:0]       mplr_d;

  mult_ctrl #(
    .N(N)
  ) u_ctrl (
    .clk   (Clk),
    .rst   (R),
    .start (Start),
    .load  (load_s),
    .shift (shift_s),
    .busy  (Busy),
    .done  (Done)
  );

  // Datapath update: load operands on acceptance, otherwise one
  // add-and-shift step per RUN cycle; hold everything in IDLE/DONE.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    if (load_s) begin
      acc_d   = '0;
      mcand_d = {{N{1'b0}}, A};
      mplr_d  = B;
    end else if (shift_s) begin
      // Full 2N-bit add; the product of two N-bit values cannot overflow it.
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d = {mcand_q[2*N-2:0], 1'b0};
      mplr_d  = {1'b0, mplr_q[N-1:1]};
    end else begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
    end
  end

  // Datapath registers; reset clears the product so an aborted result never shows.
  always_ff @(posedge Clk) begin
    if (R) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

  assign P = acc_q;

endmodule
